// File: rtl/intra16x16_mode_sched.sv
// intra16x16_mode_sched: sequencer and mode decision for the luma 16x16 intra
// predictor. Latches neighbours, derives the DC predictor, accumulates SAD for
// vertical/horizontal/DC over 16 streamed rows and reports the cheapest mode.
// Optional macro INTRA16_ABORT_EN adds an `abort` input that cancels a run.
module intra16x16_mode_sched #(
   parameter int unsigned ROWS       = 16,
   parameter int unsigned DC_DEFAULT = 128
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         top_avail,
   input  logic         left_avail,
   input  logic [127:0] top_flat,
   input  logic [127:0] left_flat,
   input  logic         orig_valid,
   input  logic [127:0] orig_row,
`ifdef INTRA16_ABORT_EN
   input  logic         abort,
`endif
   output logic         orig_ready,
   output logic         busy,
   output logic         done,
   output logic [1:0]   best_mode,
   output logic [15:0]  best_sad,
   output logic [7:0]   dc_value
);

   localparam int unsigned PIX_W    = 8;
   localparam int unsigned NPIX     = 16;
   localparam int unsigned ROW_W    = $clog2(ROWS);
   localparam int unsigned SUM_W    = 13;
   localparam int unsigned ROWSAD_W = 12;
   localparam int unsigned ACC_W    = 16;
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PREP   = 2'd1,
      S_ROWS   = 2'd2,
      S_DECIDE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_latch;
   logic               w_prep;
   logic               w_beat;
   logic               w_decide;
   logic               w_abort;
   logic               w_abort_hit;

   logic [127:0]       r_top;
   logic [127:0]       r_left;
   logic               r_top_av;
   logic               r_left_av;
   logic [PIX_W-1:0]   r_dc_work;
   logic [ROW_W-1:0]   r_row;
   logic [ACC_W-1:0]   r_sad_v;
   logic [ACC_W-1:0]   r_sad_h;
   logic [ACC_W-1:0]   r_sad_dc;

   logic               r_orig_ready;
   logic               r_busy;
   logic               r_done;
   logic [1:0]         r_best_mode;
   logic [ACC_W-1:0]   r_best_sad;
   logic [PIX_W-1:0]   r_dc_value;

   logic [SUM_W-1:0]   w_sum_top;
   logic [SUM_W-1:0]   w_sum_left;
   logic [PIX_W-1:0]   w_dc;
   logic [PIX_W-1:0]   w_left_px;
   logic [ROWSAD_W-1:0] w_row_v;
   logic [ROWSAD_W-1:0] w_row_h;
   logic [ROWSAD_W-1:0] w_row_dc;
   logic [1:0]         w_best_mode;
   logic [ACC_W-1:0]   w_best_sad;

`ifdef INTRA16_ABORT_EN
   assign w_abort = abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_abort_hit = w_abort && (r_state != S_IDLE);

   function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and control strobes; abort overrides any in-flight action
   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_prep      = 1'b0;
      w_beat      = 1'b0;
      w_decide    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_latch     = 1'b1;
               w_state_nxt = S_PREP;
            end
         end
         S_PREP: begin
            w_prep      = 1'b1;
            w_state_nxt = S_ROWS;
         end
         S_ROWS: begin
            if (orig_valid && r_orig_ready) begin
               w_beat = 1'b1;
               if (r_row == LAST_ROW) w_state_nxt = S_DECIDE;
            end
         end
         S_DECIDE: begin
            w_decide    = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_abort_hit) begin
         w_state_nxt = S_IDLE;
         w_prep      = 1'b0;
         w_beat      = 1'b0;
         w_decide    = 1'b0;
      end
   end

   // Neighbour sums and DC predictor from the latched neighbours
   always_comb begin
      w_sum_top  = '0;
      w_sum_left = '0;
      for (int unsigned c = 0; c < NPIX; c++) begin
         w_sum_top  = w_sum_top  + SUM_W'(r_top[PIX_W*c +: PIX_W]);
         w_sum_left = w_sum_left + SUM_W'(r_left[PIX_W*c +: PIX_W]);
      end
      w_dc = PIX_W'(DC_DEFAULT);
      case ({r_top_av, r_left_av})
         2'b11:   w_dc = PIX_W'((w_sum_top + w_sum_left + SUM_W'(16)) >> 5);
         2'b10:   w_dc = PIX_W'((w_sum_top + SUM_W'(8)) >> 4);
         2'b01:   w_dc = PIX_W'((w_sum_left + SUM_W'(8)) >> 4);
         default: w_dc = PIX_W'(DC_DEFAULT);
      endcase
   end

   // Per-row SAD of the incoming row against the three predictors
   always_comb begin
      w_row_v   = '0;
      w_row_h   = '0;
      w_row_dc  = '0;
      w_left_px = r_left[PIX_W*r_row +: PIX_W];
      for (int unsigned c = 0; c < NPIX; c++) begin
         w_row_v  = w_row_v  + ROWSAD_W'(absdiff(orig_row[PIX_W*c +: PIX_W], r_top[PIX_W*c +: PIX_W]));
         w_row_h  = w_row_h  + ROWSAD_W'(absdiff(orig_row[PIX_W*c +: PIX_W], w_left_px));
         w_row_dc = w_row_dc + ROWSAD_W'(absdiff(orig_row[PIX_W*c +: PIX_W], r_dc_work));
      end
   end

   // Cheapest available mode; scanned from high to low mode so ties favour the lower one
   always_comb begin
      w_best_mode = 2'd2;
      w_best_sad  = r_sad_dc;
      if (r_left_av && (r_sad_h <= w_best_sad)) begin
         w_best_mode = 2'd1;
         w_best_sad  = r_sad_h;
      end
      if (r_top_av && (r_sad_v <= w_best_sad)) begin
         w_best_mode = 2'd0;
         w_best_sad  = r_sad_v;
      end
   end

   // Neighbour latch, DC working value, row counter and SAD accumulators
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_top     <= '0;
         r_left    <= '0;
         r_top_av  <= 1'b0;
         r_left_av <= 1'b0;
         r_dc_work <= PIX_W'(DC_DEFAULT);
         r_row     <= '0;
         r_sad_v   <= '0;
         r_sad_h   <= '0;
         r_sad_dc  <= '0;
      end else if (w_abort_hit) begin
         r_row    <= '0;
         r_sad_v  <= '0;
         r_sad_h  <= '0;
         r_sad_dc <= '0;
      end else begin
         if (w_latch) begin
            r_top     <= top_flat;
            r_left    <= left_flat;
            r_top_av  <= top_avail;
            r_left_av <= left_avail;
            r_row     <= '0;
            r_sad_v   <= '0;
            r_sad_h   <= '0;
            r_sad_dc  <= '0;
         end
         if (w_prep) r_dc_work <= w_dc;
         if (w_beat) begin
            r_row    <= r_row + ROW_W'(1);
            r_sad_v  <= r_sad_v  + ACC_W'(w_row_v);
            r_sad_h  <= r_sad_h  + ACC_W'(w_row_h);
            r_sad_dc <= r_sad_dc + ACC_W'(w_row_dc);
         end
      end
   end

   // Registered handshake/status flags and result outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_orig_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_best_mode  <= 2'd2;
         r_best_sad   <= '0;
         r_dc_value   <= PIX_W'(DC_DEFAULT);
      end else begin
         r_orig_ready <= (w_state_nxt == S_ROWS);
         r_busy       <= (w_state_nxt != S_IDLE);
         r_done       <= w_decide;
         if (w_decide) begin
            r_best_mode <= w_best_mode;
            r_best_sad  <= w_best_sad;
            r_dc_value  <= r_dc_work;
         end
      end
   end

   assign orig_ready = r_orig_ready;
   assign busy       = r_busy;
   assign done       = r_done;
   assign best_mode  = r_best_mode;
   assign best_sad   = r_best_sad;
   assign dc_value   = r_dc_value;

endmodule

// File: tb/tb_intra16x16_mode_sched.sv
// Self-checking bench for intra16x16_mode_sched: a pixel-level model computes
// DC, the three SADs and the winning mode; a negedge monitor checks the result
// outputs every cycle and a driver checks latency and hand-computed literals.
`timescale 1ns/1ps
module tb_intra16x16_mode_sched;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         top_avail;
   logic         left_avail;
   logic [127:0] top_flat;
   logic [127:0] left_flat;
   logic         orig_valid;
   logic [127:0] orig_row;
   logic         orig_ready;
   logic         busy;
   logic         done;
   logic [1:0]   best_mode;
   logic [15:0]  best_sad;
   logic [7:0]   dc_value;
`ifdef INTRA16_ABORT_EN
   logic         abort;
`endif

   always #5 clk = ~clk;

   intra16x16_mode_sched dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .top_avail  (top_avail),
      .left_avail (left_avail),
      .top_flat   (top_flat),
      .left_flat  (left_flat),
      .orig_valid (orig_valid),
      .orig_row   (orig_row),
`ifdef INTRA16_ABORT_EN
      .abort      (abort),
`endif
      .orig_ready (orig_ready),
      .busy       (busy),
      .done       (done),
      .best_mode  (best_mode),
      .best_sad   (best_sad),
      .dc_value   (dc_value)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Model inputs
   bit [7:0] m_top [16];
   bit [7:0] m_left[16];
   bit [7:0] m_orig[16][16];
   bit       m_ta, m_la;

   // Currently expected result outputs and the pending result of the running block
   int exp_mode = 2, exp_sad = 0, exp_dc = 128;
   int pend_mode = 2, pend_sad = 0, pend_dc = 128;
   int n_done = 0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int iabs(input int x);
      return (x < 0) ? -x : x;
   endfunction

   // Reference: predictor and SADs straight from the pixel definitions
   task automatic model();
      int st, sl, dc, best, bs;
      int sad[3];
      bit avail[3];
      st = 0; sl = 0;
      for (int c = 0; c < 16; c++) begin
         st += m_top[c];
         sl += m_left[c];
      end
      if (m_ta && m_la) dc = (st + sl + 16) / 32;
      else if (m_ta)    dc = (st + 8) / 16;
      else if (m_la)    dc = (sl + 8) / 16;
      else              dc = 128;
      sad = '{0, 0, 0};
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            sad[0] += iabs(int'(m_orig[r][c]) - int'(m_top[c]));
            sad[1] += iabs(int'(m_orig[r][c]) - int'(m_left[r]));
            sad[2] += iabs(int'(m_orig[r][c]) - dc);
         end
      avail = '{m_ta, m_la, 1'b1};
      best = -1; bs = 0;
      for (int m = 0; m < 3; m++)
         if (avail[m] && (best < 0 || sad[m] < bs)) begin
            best = m;
            bs   = sad[m];
         end
      pend_mode = best;
      pend_sad  = bs;
      pend_dc   = dc;
   endtask

   task automatic set_uniform(input bit ta, input bit la, input int tv, input int lv, input int ov);
      m_ta = ta; m_la = la;
      for (int i = 0; i < 16; i++) begin
         m_top[i]  = 8'(tv);
         m_left[i] = 8'(lv);
         for (int c = 0; c < 16; c++) m_orig[i][c] = 8'(ov);
      end
   endtask

   // Result monitor: outputs may only change in the cycle done is high
   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_mode = pend_mode;
         exp_sad  = pend_sad;
         exp_dc   = pend_dc;
         n_done++;
         chk("done_single_cycle", 32'(prev_done), 0);
         chk("busy_low_at_done", 32'(busy), 0);
      end
      prev_done = done;
      chk("best_mode", 32'(best_mode), exp_mode);
      chk("best_sad", 32'(best_sad), exp_sad);
      chk("dc_value", 32'(dc_value), exp_dc);
   end

   // Drive one macroblock; vmode 1 toggles orig_valid, stop_after>0 quits after that many beats
   task automatic run_mb(input int vmode, input int stop_after, input bit mid_start, input int exp_lat);
      int cyc, ri, lat, rsel;
      model();
      @(posedge clk); #1;
      top_avail  = m_ta;
      left_avail = m_la;
      for (int c = 0; c < 16; c++) begin
         top_flat[8*c +: 8]  = m_top[c];
         left_flat[8*c +: 8] = m_left[c];
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; ri = 0; lat = 0;
      chk("busy_in_prep", 32'(busy), 1);
      chk("ready_low_in_prep", 32'(orig_ready), 0);
      while (cyc < 80) begin
         orig_valid = (vmode == 0) ? 1'b1 : ((cyc % 2) == 1);
         rsel = (ri < 16) ? ri : 15;
         for (int c = 0; c < 16; c++) orig_row[8*c +: 8] = m_orig[rsel][c];
         start = mid_start && (cyc == 10);
         @(negedge clk);
         if (done === 1'b1) begin
            lat = cyc;
            break;
         end
         if (orig_valid && orig_ready) ri++;
         @(posedge clk); #1;
         cyc++;
         if (stop_after > 0 && ri == stop_after) break;
      end
      orig_valid = 1'b0;
      start      = 1'b0;
      if (stop_after == 0) begin
         chk("done_latency", lat, exp_lat);
         chk("rows_consumed", ri, 16);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int n0;
      reset = 1'b1; start = 1'b0; top_avail = 1'b0; left_avail = 1'b0;
      top_flat = '0; left_flat = '0; orig_valid = 1'b0; orig_row = '0;
`ifdef INTRA16_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(orig_ready), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_mode", 32'(best_mode), 2);
      chk("rst_sad", 32'(best_sad), 0);
      chk("rst_dc", 32'(dc_value), 128);
      reset = 1'b0;

      // Both available, orig matches top
      set_uniform(1, 1, 10, 20, 10);
      run_mb(0, 0, 0, 19);
      chk("t1_mode", 32'(best_mode), 0);
      chk("t1_sad", 32'(best_sad), 0);
      chk("t1_dc", 32'(dc_value), 15);

      // Top unavailable, rows match their left neighbour
      set_uniform(0, 1, 0, 0, 0);
      for (int r = 0; r < 16; r++) begin
         m_left[r] = 8'(16 * r);
         for (int c = 0; c < 16; c++) m_orig[r][c] = 8'(16 * r);
      end
      run_mb(0, 0, 0, 19);
      chk("t2_mode", 32'(best_mode), 1);
      chk("t2_sad", 32'(best_sad), 0);
      chk("t2_dc", 32'(dc_value), 120);

      // Neither available: unavailable neighbours equal orig and must be ignored
      set_uniform(0, 0, 200, 200, 200);
      run_mb(0, 0, 0, 19);
      chk("t3_mode", 32'(best_mode), 2);
      chk("t3_sad", 32'(best_sad), 18432);
      chk("t3_dc", 32'(dc_value), 128);

      // Three-way tie resolves to vertical
      set_uniform(1, 1, 50, 50, 60);
      run_mb(0, 0, 0, 19);
      chk("t4_mode", 32'(best_mode), 0);
      chk("t4_sad", 32'(best_sad), 2560);
      chk("t4_dc", 32'(dc_value), 50);

      // Toggled valid and a stray start mid-rows
      set_uniform(1, 1, 10, 20, 10);
      run_mb(1, 0, 1, 35);
      chk("t5_mode", 32'(best_mode), 0);
      chk("t5_sad", 32'(best_sad), 0);
      chk("t5_dc", 32'(dc_value), 15);

      // Reset after 8 rows, then a fresh run
      set_uniform(1, 1, 50, 50, 60);
      run_mb(0, 8, 0, 0);
      reset = 1'b1;
      exp_mode = 2; exp_sad = 0; exp_dc = 128;
      #1;
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_ready", 32'(orig_ready), 0);
      chk("t6_rst_mode", 32'(best_mode), 2);
      chk("t6_rst_dc", 32'(dc_value), 128);
      @(posedge clk); #1;
      reset = 1'b0;
      set_uniform(0, 0, 200, 200, 200);
      run_mb(0, 0, 0, 19);
      chk("t6_mode", 32'(best_mode), 2);
      chk("t6_sad", 32'(best_sad), 18432);

`ifdef INTRA16_ABORT_EN
      // Abort after 5 rows keeps the previous result and never pulses done
      set_uniform(1, 1, 10, 20, 10);
      n0 = n_done;
      run_mb(0, 5, 0, 0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("ab_ready", 32'(orig_ready), 0);
      chk("ab_busy", 32'(busy), 0);
      repeat (5) @(posedge clk);
      #1;
      chk("ab_no_done", n_done - n0, 0);
      chk("ab_sad_kept", 32'(best_sad), 18432);
      run_mb(0, 0, 0, 19);
      chk("ab_rerun_mode", 32'(best_mode), 0);
      chk("ab_rerun_dc", 32'(dc_value), 15);
`else
      n0 = n_done;
`endif

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1);
   end

endmodule
